// File: rtl/adc_scan_sequencer_pkg.sv
// Shared constants for the ADC scan sequencer: register map, bit positions
// and FSM state encodings.
package adc_seq_pkg;

  // Register bus word address width inside the sequencer window
  localparam int ADDR_W = 4;

  // Register word indices
  localparam logic [ADDR_W-1:0] REG_CTRL     = 4'd0;
  localparam logic [ADDR_W-1:0] REG_INTERVAL = 4'd1;
  localparam logic [ADDR_W-1:0] REG_STATUS   = 4'd2;
  localparam int                RESULT_BASE  = 8;

  // CTRL bit positions
  localparam int CTRL_RUN_BIT    = 0;
  localparam int CTRL_SINGLE_BIT = 1;
  localparam int CTRL_UNI_BIT    = 2;
  localparam int CTRL_MASK_LSB   = 8;

  // STATUS bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_TMO_BIT  = 1;
  localparam int STATUS_CH_LSB   = 8;
  localparam int STATUS_CNT_LSB  = 16;
  localparam int SCAN_CNT_W      = 16;

  // RESULT bit positions
  localparam int RESULT_FRESH_BIT = 31;

  // Sequencer FSM states
  typedef logic [2:0] seq_state_t;
  localparam seq_state_t ST_IDLE     = 3'd0;
  localparam seq_state_t ST_SELECT   = 3'd1;
  localparam seq_state_t ST_ISSUE    = 3'd2;
  localparam seq_state_t ST_WAIT     = 3'd3;
  localparam seq_state_t ST_STORE    = 3'd4;
  localparam seq_state_t ST_DONE     = 3'd5;
  localparam seq_state_t ST_INTERVAL = 3'd6;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// CPU register bus as seen by the scan sequencer: one-cycle read/write
// strobes, word address, write data and registered read data.
interface adc_scan_sequencer_if
  import adc_seq_pkg::*;
#(
  parameter int BusWidth = 32
);
  logic                wr_en;
  logic                rd_en;
  logic [ADDR_W-1:0]   addr;
  logic [BusWidth-1:0] wdata;
  logic [BusWidth-1:0] rdata;

  // CPU side drives strobes, address and write data
  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  // Sequencer side answers with read data
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/adc_scan_sequencer_next_chan.sv
// Finds the lowest enabled channel at or above the current scan index.
// index_i may equal NumChan, meaning the scan has passed the last channel.
module adc_next_chan
  import adc_seq_pkg::*;
#(
  parameter int NumChan = 8
) (
  input  logic [NumChan-1:0]         mask_i,
  input  logic [$clog2(NumChan):0]   index_i,
  output logic [$clog2(NumChan)-1:0] ch_o,
  output logic                       found_o
);
  localparam int ChW  = $clog2(NumChan);
  localparam int IdxW = ChW + 1;

  logic [NumChan-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < NumChan; gi++) begin : g_cand
      assign cand[gi] = mask_i[gi] && (IdxW'(gi) >= index_i);
    end
  endgenerate

  // Priority pick: walking downwards leaves the lowest candidate in ch_o
  always_comb begin
    ch_o    = '0;
    found_o = 1'b0;
    for (int i = NumChan - 1; i >= 0; i--) begin
      if (cand[i]) begin
        ch_o    = ChW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Autonomous LTC2308 scan controller: walks the enabled channels in
// ascending order, runs one conversion per channel, keeps the latest
// result per channel and repeats scans after a programmable gap.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NumChan    = 8,
  parameter int DataWidth  = 12,
  parameter int BusWidth   = 32,
  parameter int IntWidth   = 16,
  parameter int TimeoutCyc = 1024
) (
  input  logic                       reg_clk,
  input  logic                       reset_in,
  adc_scan_sequencer_if.slave        bus,
  output logic                       adc_start,
  output logic [$clog2(NumChan)-1:0] adc_ch,
  output logic                       adc_uni,
  input  logic                       adc_busy,
  input  logic                       adc_valid,
  input  logic [DataWidth-1:0]       adc_data,
  output logic                       scan_done
);
  localparam int ChW  = $clog2(NumChan);
  localparam int IdxW = ChW + 1;
  localparam int TmoW = $clog2(TimeoutCyc);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCyc - 1);

  // Programmer-visible registers
  logic                  ctrl_run_q;
  logic                  ctrl_single_q;
  logic                  ctrl_uni_q;
  logic [NumChan-1:0]    ctrl_mask_q;
  logic [IntWidth-1:0]   interval_q;
  logic                  timeout_q;
  logic [SCAN_CNT_W-1:0] scan_cnt_q;
  logic [DataWidth-1:0]  result_data_q [NumChan];
  logic [NumChan-1:0]    result_fresh_q;
  logic [BusWidth-1:0]   rdata_q;

  // Sequencer state
  seq_state_t           state_q, state_d;
  logic [IdxW-1:0]      index_q, index_d;
  logic [ChW-1:0]       cur_ch_q, cur_ch_d;
  logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [IntWidth-1:0]  ival_cnt_q, ival_cnt_d;
  logic [NumChan-1:0]   scan_mask_q, scan_mask_d;
  logic                 scan_uni_q, scan_uni_d;
  logic                 scan_run_q, scan_run_d;
  logic [DataWidth-1:0] sample_q, sample_d;
  logic                 start_q, start_d;
  logic                 done_q, done_d;
  logic                 timeout_set;

  logic [ChW-1:0]       nc_ch;
  logic                 nc_found;
  logic                 abort_scan;
  logic [IdxW-1:0]      index_after_cur;

  logic                 wr_ctrl, wr_interval, wr_status;
  logic [NumChan-1:0]   res_sel, rd_result_hit, store_hit;
  logic [BusWidth-1:0]  rd_word;
  logic                 unused_wdata;

  assign wr_ctrl     = bus.wr_en && (bus.addr == REG_CTRL);
  assign wr_interval = bus.wr_en && (bus.addr == REG_INTERVAL);
  assign wr_status   = bus.wr_en && (bus.addr == REG_STATUS);

  genvar gi;
  generate
    for (gi = 0; gi < NumChan; gi++) begin : g_result_dec
      assign res_sel[gi]       = (bus.addr == ADDR_W'(RESULT_BASE + gi));
      assign rd_result_hit[gi] = bus.rd_en && res_sel[gi];
      assign store_hit[gi]     = (state_q == ST_STORE) && (cur_ch_q == ChW'(gi));
    end
  endgenerate

  // Only the low half of the write bus carries register fields
  assign unused_wdata = ^bus.wdata[BusWidth-1:IntWidth];

  adc_next_chan #(
    .NumChan (NumChan)
  ) u_next_chan (
    .mask_i  (scan_mask_q),
    .index_i (index_q),
    .ch_o    (nc_ch),
    .found_o (nc_found)
  );

  // A run-mode scan whose run bit was cleared finishes the current
  // conversion and then drops to IDLE without a scan_done
  assign abort_scan      = scan_run_q && !ctrl_run_q;
  assign index_after_cur = IdxW'(cur_ch_q) + IdxW'(1);

  // Next-state logic for the scan FSM and its counters
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    cur_ch_d    = cur_ch_q;
    tmo_cnt_d   = tmo_cnt_q;
    ival_cnt_d  = ival_cnt_q;
    scan_mask_d = scan_mask_q;
    scan_uni_d  = scan_uni_q;
    scan_run_d  = scan_run_q;
    sample_d    = sample_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((ctrl_run_q || ctrl_single_q) && (ctrl_mask_q != '0)) begin
          scan_mask_d = ctrl_mask_q;
          scan_uni_d  = ctrl_uni_q;
          scan_run_d  = ctrl_run_q;
          index_d     = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (nc_found) begin
          cur_ch_d = nc_ch;
          state_d  = ST_ISSUE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (!adc_busy) begin
          start_d   = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (adc_valid) begin
          sample_d = adc_data;
          state_d  = ST_STORE;
        end else if (tmo_cnt_q == TmoLast) begin
          timeout_set = 1'b1;
          index_d     = index_after_cur;
          state_d     = abort_scan ? ST_IDLE : ST_SELECT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_STORE: begin
        index_d = index_after_cur;
        state_d = abort_scan ? ST_IDLE : ST_SELECT;
      end
      ST_DONE: begin
        done_d     = 1'b1;
        ival_cnt_d = '0;
        state_d    = ctrl_run_q ? ST_INTERVAL : ST_IDLE;
      end
      ST_INTERVAL: begin
        if (!ctrl_run_q) begin
          state_d = ST_IDLE;
        end else if (ival_cnt_q == interval_q) begin
          // New scan: pick up any CTRL changes made during the last one
          if (ctrl_mask_q != '0) begin
            scan_mask_d = ctrl_mask_q;
            scan_uni_d  = ctrl_uni_q;
            scan_run_d  = 1'b1;
            index_d     = '0;
            state_d     = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ival_cnt_d = ival_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, counters and ADC-facing output registers
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      cur_ch_q    <= '0;
      tmo_cnt_q   <= '0;
      ival_cnt_q  <= '0;
      scan_mask_q <= '0;
      scan_uni_q  <= 1'b0;
      scan_run_q  <= 1'b0;
      sample_q    <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cur_ch_q    <= cur_ch_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ival_cnt_q  <= ival_cnt_d;
      scan_mask_q <= scan_mask_d;
      scan_uni_q  <= scan_uni_d;
      scan_run_q  <= scan_run_d;
      sample_q    <= sample_d;
      start_q     <= start_d;
      done_q      <= done_d;
    end
  end

  // CTRL / INTERVAL / STATUS registers; a timeout beats a same-cycle clear
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      ctrl_run_q    <= 1'b0;
      ctrl_single_q <= 1'b0;
      ctrl_uni_q    <= 1'b0;
      ctrl_mask_q   <= '0;
      interval_q    <= '0;
      timeout_q     <= 1'b0;
      scan_cnt_q    <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_run_q    <= bus.wdata[CTRL_RUN_BIT];
        ctrl_single_q <= bus.wdata[CTRL_SINGLE_BIT];
        ctrl_uni_q    <= bus.wdata[CTRL_UNI_BIT];
        ctrl_mask_q   <= bus.wdata[CTRL_MASK_LSB +: NumChan];
      end else if (ctrl_single_q) begin
        ctrl_single_q <= 1'b0;
      end
      if (wr_interval) begin
        interval_q <= bus.wdata[IntWidth-1:0];
      end
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end else if (wr_status && bus.wdata[STATUS_TMO_BIT]) begin
        timeout_q <= 1'b0;
      end
      if (state_q == ST_DONE) begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
    end
  end

  // Per-channel results; a store wins over a same-cycle read-clear of fresh
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NumChan; i++) begin
        result_data_q[i] <= '0;
      end
      result_fresh_q <= '0;
    end else begin
      for (int i = 0; i < NumChan; i++) begin
        if (store_hit[i]) begin
          result_data_q[i]  <= sample_q;
          result_fresh_q[i] <= 1'b1;
        end else if (rd_result_hit[i]) begin
          result_fresh_q[i] <= 1'b0;
        end
      end
    end
  end

  // Read mux over pre-write register contents
  always_comb begin
    rd_word = '0;
    if (bus.addr == REG_CTRL) begin
      rd_word[CTRL_RUN_BIT]              = ctrl_run_q;
      rd_word[CTRL_SINGLE_BIT]           = ctrl_single_q;
      rd_word[CTRL_UNI_BIT]              = ctrl_uni_q;
      rd_word[CTRL_MASK_LSB +: NumChan]  = ctrl_mask_q;
    end else if (bus.addr == REG_INTERVAL) begin
      rd_word[IntWidth-1:0] = interval_q;
    end else if (bus.addr == REG_STATUS) begin
      rd_word[STATUS_BUSY_BIT]               = (state_q != ST_IDLE);
      rd_word[STATUS_TMO_BIT]                = timeout_q;
      rd_word[STATUS_CH_LSB +: ChW]          = cur_ch_q;
      rd_word[STATUS_CNT_LSB +: SCAN_CNT_W]  = scan_cnt_q;
    end else begin
      for (int i = 0; i < NumChan; i++) begin
        if (res_sel[i]) begin
          rd_word[RESULT_FRESH_BIT] = result_fresh_q[i];
          rd_word[DataWidth-1:0]    = result_data_q[i];
        end
      end
    end
  end

  // Read data register holds its value between reads
  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      rdata_q <= '0;
    end else if (bus.rd_en) begin
      rdata_q <= rd_word;
    end
  end

  assign bus.rdata = rdata_q;
  assign adc_start = start_q;
  assign adc_ch    = cur_ch_q;
  assign adc_uni   = scan_uni_q;
  assign scan_done = done_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC core model.
module tb_adc_scan_sequencer;
  import adc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        adc_start;
  logic [2:0]  adc_ch;
  logic        adc_uni;
  logic        adc_busy;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic        scan_done;

  adc_scan_sequencer_if #(.BusWidth(32)) bus ();

  adc_scan_sequencer dut (
    .reg_clk   (clk),
    .reset_in  (reset_in),
    .bus       (bus),
    .adc_start (adc_start),
    .adc_ch    (adc_ch),
    .adc_uni   (adc_uni),
    .adc_busy  (adc_busy),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ADC model state and observation counters
  int busy_force = 0;
  int drop_ch    = 8;
  int pending    = 0;
  int pend_ch    = 0;
  int lat_cnt    = 0;
  int cyc        = 0;
  int starts [8];
  int starts_cyc = 0;
  int stab_err   = 0;
  int done_cnt   = 0;
  int start_at   = 0;
  int done_at    = 0;
  int start_log [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ADC core: 20-cycle conversion, data = 0x100 + channel, optional dropped channel
  initial begin
    adc_busy  = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
  end

  always @(negedge clk) begin
    adc_valid = 1'b0;
    if (pending != 0) begin
      if (int'(adc_ch) != pend_ch) stab_err++;
      lat_cnt--;
      if (lat_cnt == 0) begin
        pending = 0;
        if (pend_ch != drop_ch) begin
          adc_valid = 1'b1;
          adc_data  = 12'h100 + 12'(pend_ch);
        end
      end
    end
    if (adc_start) begin
      starts_cyc++;
      if (pending == 0) begin
        pending  = 1;
        pend_ch  = int'(adc_ch);
        lat_cnt  = 20;
        starts[adc_ch]++;
        start_log.push_back(int'(adc_ch));
        start_at = cyc;
      end
    end
    if (scan_done) begin
      done_cnt++;
      done_at = cyc;
    end
    adc_busy = (pending != 0) || (busy_force != 0);
    cyc++;
  end

  task automatic clear_stats();
    for (int i = 0; i < 8; i++) starts[i] = 0;
    starts_cyc = 0;
    stab_err   = 0;
    start_log.delete();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    $display("WR  addr=%0d data=0x%08h", a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    d = bus.rdata;
    $display("RD  addr=%0d data=0x%08h", a, d);
  endtask

  task automatic bus_wr_rd(input logic [3:0] a, input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    q = bus.rdata;
    $display("WRD addr=%0d wdata=0x%08h rdata=0x%08h", a, d, q);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_start(input int ch, input int budget, input string tag);
    int n = 0;
    while (starts[ch] == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(starts[ch] != 0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int base;
    int others;
    int lat;
    int ch_bad;

    reset_in  = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;

    // Reset state
    check_val("rst_adc_start", 32'(adc_start), 0);
    check_val("rst_adc_ch", 32'(adc_ch), 0);
    check_val("rst_scan_done", 32'(scan_done), 0);
    check_val("rst_rdata", bus.rdata, 0);
    bus_read(REG_CTRL, rd);    check_val("rst_ctrl", rd, 0);
    bus_read(REG_STATUS, rd);  check_val("rst_status", rd, 0);
    bus_read(4'd8, rd);        check_val("rst_result0", rd, 0);
    bus_read(4'd5, rd);        check_val("rsvd_reg5", rd, 0);

    // Same-cycle write and read returns the old value
    bus_wr_rd(REG_INTERVAL, 32'd7, rd); check_val("wrrd_old_value", rd, 0);
    bus_read(REG_INTERVAL, rd);         check_val("wrrd_new_value", rd, 7);
    bus_write(REG_INTERVAL, 32'd0);

    // T1: continuous scan of ch0 and ch2, interval 0
    clear_stats();
    base = done_cnt;
    bus_write(REG_CTRL, 32'h0000_0501);
    wait_done(base + 2, 400, "t1_two_scans");
    bus_write(REG_CTRL, 32'h0000_0500);
    repeat (100) @(negedge clk);
    others = 0;
    for (int i = 0; i < 8; i++) if (i != 0 && i != 2) others += starts[i];
    check_val("t1_other_ch_starts", others, 0);
    check_val("t1_ch0_runs", 32'(starts[0] >= 2), 1);
    check_val("t1_ch2_runs", 32'(starts[2] >= 2), 1);
    check_val("t1_order_first", start_log[0], 0);
    check_val("t1_order_second", start_log[1], 2);
    check_val("t1_adc_uni", 32'(adc_uni), 0);
    bus_read(4'd8, rd);  check_val("t1_result0", rd, 32'h8000_0100);
    bus_read(4'd10, rd); check_val("t1_result2", rd, 32'h8000_0102);
    bus_read(REG_STATUS, rd);
    check_val("t1_status_busy_tmo", rd[1:0], 0);
    check_val("t1_scan_count", rd[31:16], done_cnt);

    // T2: single scan of all channels
    clear_stats();
    base = done_cnt;
    bus_write(REG_CTRL, 32'h0000_FF06);
    bus_read(REG_CTRL, rd); check_val("t2_single_selfclear", rd, 32'h0000_FF04);
    check_val("t2_adc_uni", 32'(adc_uni), 1);
    wait_done(base + 1, 600, "t2_scan_done");
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) check_val($sformatf("t2_starts_ch%0d", i), starts[i], 1);
    check_val("t2_one_scan_done", done_cnt, base + 1);
    bus_read(REG_STATUS, rd);
    check_val("t2_idle", rd[0], 0);
    check_val("t2_scan_count", rd[31:16], done_cnt);
    bus_read(4'd15, rd); check_val("t2_result7_fresh", rd, 32'h8000_0107);
    bus_read(4'd15, rd); check_val("t2_result7_stale", rd, 32'h0000_0107);
    repeat (5) @(negedge clk);
    check_val("t2_rdata_hold", bus.rdata, 32'h0000_0107);

    // T3: ch3 never answers -> timeout
    drop_ch = 3;
    clear_stats();
    base = done_cnt;
    bus_write(REG_CTRL, 32'h0000_0802);
    wait_done(base + 1, 1300, "t3_scan_done");
    lat = done_at - start_at;
    $display("INFO t3 start-to-scan_done latency %0d cycles", lat);
    check_val("t3_tmo_latency_1024_1040", 32'(lat >= 1024 && lat <= 1040), 1);
    bus_read(REG_STATUS, rd); check_val("t3_tmo_set", rd[1], 1);
    bus_read(4'd11, rd);      check_val("t3_result3_unchanged", rd, 32'h8000_0103);
    bus_write(REG_STATUS, 32'h0000_0002);
    bus_read(REG_STATUS, rd); check_val("t3_tmo_cleared", rd[1], 0);
    drop_ch = 8;

    // T4: ADC busy holds off the start request
    busy_force = 1;
    repeat (2) @(negedge clk);
    clear_stats();
    base = done_cnt;
    bus_write(REG_CTRL, 32'h0000_1002);
    repeat (5) @(negedge clk);
    ch_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_ch !== 3'd4) ch_bad++;
    end
    check_val("t4_no_start_while_busy", starts_cyc, 0);
    check_val("t4_ch_stable_in_issue", ch_bad, 0);
    busy_force = 0;
    wait_done(base + 1, 200, "t4_scan_done");
    check_val("t4_single_start_pulse", starts_cyc, 1);
    check_val("t4_ch_stable_in_wait", stab_err, 0);
    bus_read(4'd12, rd); check_val("t4_result4", rd, 32'h8000_0104);

    // T5: clear run during ch1 conversion
    bus_read(4'd9, rd); check_val("t5_result1_pre", rd, 32'h8000_0101);
    bus_write(REG_INTERVAL, 32'd100);
    clear_stats();
    base = done_cnt;
    bus_write(REG_CTRL, 32'h0000_0601);
    wait_start(1, 100, "t5_ch1_started");
    repeat (3) @(negedge clk);
    bus_write(REG_CTRL, 32'h0000_0600);
    repeat (150) @(negedge clk);
    check_val("t5_no_scan_done", done_cnt, base);
    check_val("t5_ch2_not_started", starts[2], 0);
    bus_read(REG_STATUS, rd); check_val("t5_idle", rd[0], 0);
    bus_read(4'd9, rd);       check_val("t5_result1_stored", rd, 32'h8000_0101);
    repeat (200) @(negedge clk);
    check_val("t5_no_further_start", starts_cyc, 1);

    // T6: asynchronous reset in the middle of a conversion
    clear_stats();
    bus_write(REG_CTRL, 32'h0000_8005);
    wait_start(7, 100, "t6_ch7_started");
    bus_read(REG_CTRL, rd); check_val("t6_ctrl_before", rd, 32'h0000_8005);
    repeat (3) @(negedge clk);
    check_val("t6_adc_ch_before", 32'(adc_ch), 7);
    check_val("t6_adc_uni_before", 32'(adc_uni), 1);
    #2 reset_in = 1'b1;
    #1;
    check_val("t6_async_adc_ch", 32'(adc_ch), 0);
    check_val("t6_async_adc_uni", 32'(adc_uni), 0);
    check_val("t6_async_adc_start", 32'(adc_start), 0);
    check_val("t6_async_scan_done", 32'(scan_done), 0);
    check_val("t6_async_rdata", bus.rdata, 0);
    repeat (2) @(negedge clk);
    reset_in = 1'b0;
    repeat (40) @(negedge clk);
    check_val("t6_no_start_after_reset", starts_cyc, 1);
    bus_read(REG_STATUS, rd);   check_val("t6_status", rd, 0);
    bus_read(REG_CTRL, rd);     check_val("t6_ctrl", rd, 0);
    bus_read(REG_INTERVAL, rd); check_val("t6_interval", rd, 0);
    bus_read(4'd15, rd);        check_val("t6_result7", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
